// File: rtl/uart_bootloader.sv
// UART boot front end: receives a framed program image, writes it word by word
// into instruction memory, answers ACK/NAK and releases the core once verified.
`timescale 1ns/1ps
module uart_bootloader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4096,
    parameter int ADDR_W       = 12,
    parameter int BASE_WORD    = 0,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic              i_rx,
    output logic              o_tx,
    output logic              o_booted,
    output logic              o_core_rst,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata
);
    localparam int BAUD_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);
    localparam logic [16:0]       MAX_WORDS = 17'(DEPTH - BASE_WORD);
    localparam logic [7:0] MAGIC = 8'hB0;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, PAYLOAD, CSUM, RESP, BOOTED} state_t;

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_valid_s, rx_ferr_s;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d, word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              tx_q, tx_d, ack_q, ack_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [3:0]        tx_bits_q, tx_bits_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic              booted_q, booted_d, core_rst_q, core_rst_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_start_s;
    logic [7:0]        resp_byte_s;
    logic [15:0]       n_s;

    // Byte receiver: start-bit qualification at half a bit, then centre sampling.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q + BAUD_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_s = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_baud_d = '0;
                rx_bit_d  = 3'd0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
                else                         rx_state_d = RX_IDLE;
            end
            RX_START: begin
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_state_d = RX_DATA;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_valid_s = rx_sync_q;
                    rx_ferr_s  = !rx_sync_q;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame parser, memory write strobe, response transmitter and boot status.
    always_comb begin
        state_d = state_q;         cnt_d = cnt_q;           word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;   word_d = word_q;         csum_d = csum_q;
        to_cnt_d = '0;             tx_d = tx_q;             ack_d = ack_q;
        tx_shift_d = tx_shift_q;   tx_bits_d = tx_bits_q;   tx_baud_d = tx_baud_q;
        booted_d = booted_q;       core_rst_d = core_rst_q; mem_we_d = 1'b0;
        mem_addr_d = mem_addr_q;   mem_wdata_d = mem_wdata_q;
        resp_start_s = 1'b0;       resp_byte_s = NAK;
        n_s = {rx_shift_q, cnt_q[7:0]};
        case (state_q)
            IDLE: begin
                if (rx_valid_s && rx_shift_q == MAGIC) state_d = CNT_LO;
                else                                   state_d = IDLE;
            end
            CNT_LO, CNT_HI, PAYLOAD, CSUM: begin
                if (rx_state_q != RX_IDLE) to_cnt_d = '0;
                else                       to_cnt_d = to_cnt_q + TO_W'(1);
                if (rx_ferr_s || to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                end else if (rx_valid_s) begin
                    case (state_q)
                        CNT_LO: begin
                            cnt_d[7:0] = rx_shift_q;
                            state_d    = CNT_HI;
                        end
                        CNT_HI: begin
                            if (n_s == 16'd0 || {1'b0, n_s} > MAX_WORDS) begin
                                resp_start_s = 1'b1;
                            end else begin
                                cnt_d      = n_s;
                                word_idx_d = 16'd0;
                                byte_idx_d = 2'd0;
                                csum_d     = 8'd0;
                                state_d    = PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            csum_d     = csum_q + rx_shift_q;
                            word_d     = {rx_shift_q, word_q[31:8]};
                            byte_idx_d = byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = ADDR_W'(BASE_WORD) + word_idx_q[ADDR_W-1:0];
                                mem_wdata_d = {rx_shift_q, word_q[31:8]};
                                if (word_idx_q == cnt_q - 16'd1) state_d = CSUM;
                                else word_idx_d = word_idx_q + 16'd1;
                            end else begin
                                mem_we_d = 1'b0;
                            end
                        end
                        CSUM: begin
                            resp_start_s = 1'b1;
                            resp_byte_s  = (rx_shift_q == csum_q) ? ACK : NAK;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            RESP: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d = '0;
                    if (tx_bits_q == 4'd0) begin
                        if (ack_q) begin
                            state_d    = BOOTED;
                            booted_d   = 1'b1;
                            core_rst_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[7:1]};
                        tx_bits_d  = tx_bits_q - 4'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            BOOTED:  state_d = BOOTED;
            default: state_d = IDLE;
        endcase
        // Shifting 1s in behind the data makes the ninth slot the stop bit.
        if (resp_start_s) begin
            state_d    = RESP;
            tx_d       = 1'b0;
            tx_shift_d = resp_byte_s;
            tx_bits_d  = 4'd9;
            tx_baud_d  = '0;
            ack_d      = (resp_byte_s == ACK);
        end else begin
            ack_d = ack_q;
        end
    end

    // State registers; everything, including the synchroniser, advances only on enabled cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;  rx_sync_q <= 1'b1;  rx_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE; rx_baud_q <= '0; rx_bit_q <= 3'd0; rx_shift_q <= 8'd0;
            state_q <= IDLE;    cnt_q <= 16'd0;     word_idx_q <= 16'd0;
            byte_idx_q <= 2'd0; word_q <= 32'd0;    csum_q <= 8'd0;
            to_cnt_q <= '0;     tx_q <= 1'b1;       ack_q <= 1'b0;
            tx_shift_q <= 8'd0; tx_bits_q <= 4'd0;  tx_baud_q <= '0;
            booted_q <= 1'b0;   core_rst_q <= 1'b1; mem_we_q <= 1'b0;
            mem_addr_q <= '0;   mem_wdata_q <= 32'd0;
        end else if (i_clk_en) begin
            rx_meta_q <= i_rx;  rx_sync_q <= rx_meta_q; rx_prev_q <= rx_sync_q;
            rx_state_q <= rx_state_d; rx_baud_q <= rx_baud_d; rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d;
            state_q <= state_d;       cnt_q <= cnt_d;         word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d; word_q <= word_d;       csum_q <= csum_d;
            to_cnt_q <= to_cnt_d;     tx_q <= tx_d;           ack_q <= ack_d;
            tx_shift_q <= tx_shift_d; tx_bits_q <= tx_bits_d; tx_baud_q <= tx_baud_d;
            booted_q <= booted_d;     core_rst_q <= core_rst_d; mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
        end
    end

    assign o_tx        = tx_q;
    assign o_booted    = booted_q;
    assign o_core_rst  = core_rst_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_uart_bootloader.sv
// Bench for uart_bootloader: directed frame table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_bootloader;
    localparam int CPB    = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_en;
    logic              rx = 1'b1;
    logic              tx, booted, core_rst, we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    int          checks = 0;
    int          failures = 0;
    bit          half = 1'b0;
    logic [31:0] pay [DEPTH];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          tx_q[$];
    logic [7:0]  tx_b;

    typedef struct {
        int          n;
        logic [31:0] w0, w1;
        int          csum;      // -1: send the correct checksum
        bit          half;
        int          exp_resp;  // response byte
        bit          exp_boot;
    } vec_t;
    vec_t vt[7];

    uart_bootloader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                      .BASE_WORD(0), .TIMEOUT_BITS(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_rx(rx), .o_tx(tx),
        .o_booted(booted), .o_core_rst(core_rst), .o_mem_we(we),
        .o_mem_addr(addr), .o_mem_wdata(wdata));

    always #5 clk = ~clk;

    initial begin
        clk_en = 1'b1;
        forever begin
            @(negedge clk);
            clk_en = half ? ~clk_en : 1'b1;
        end
    end

    // one enabled clock edge; clk_en seen at edge+1 is the value that edge used
    task automatic tick();
        do begin
            @(posedge clk);
            #1;
        end while (!clk_en);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (we && clk_en) begin
            wr_addr_q.push_back(int'(addr));
            wr_data_q.push_back(wdata);
        end
    end

    initial forever begin
        tick();
        if (tx === 1'b0) begin
            repeat (CPB / 2) tick();
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) tick();
                tx_b[i] = tx;
            end
            repeat (CPB) tick();
            tx_q.push_back(tx ? int'(tx_b) : -1);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        rx = 1'b1;
        if (!stop) repeat (2 * CPB) tick();
    endtask

    function automatic logic [7:0] sum_pay(input int n);
        logic [7:0] s = 8'd0;
        for (int w = 0; w < n; w++)
            for (int k = 0; k < 4; k++) s = s + pay[w][8*k +: 8];
        return s;
    endfunction

    function automatic int model_writes(input int n);
        return (n >= 1 && n <= DEPTH) ? n : 0;
    endfunction

    function automatic int model_resp(input int n, input int csum);
        if (n == 0 || n > DEPTH) return 'h15;
        return (csum[7:0] == sum_pay(n)) ? 'h06 : 'h15;
    endfunction

    // bytes[first..last] of the frame; the byte at bad_idx gets a 0 stop bit and ends the send
    task automatic send_frame(input int n, input int csum, input int bad_idx, input int first, input int last);
        logic [7:0] bytes[$];
        bytes.push_back(8'hB0);
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        if (n >= 1 && n <= DEPTH) begin
            for (int w = 0; w < n; w++)
                for (int k = 0; k < 4; k++) bytes.push_back(pay[w][8*k +: 8]);
            bytes.push_back(csum[7:0]);
        end
        for (int i = first; i < bytes.size(); i++) begin
            if (last >= 0 && i > last) break;
            send_byte(bytes[i], i != bad_idx);
            if (i == bad_idx) break;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic fill_pay(input logic [31:0] w0, input logic [31:0] w1);
        pay[0] = w0;
        pay[1] = w1;
        for (int i = 2; i < DEPTH; i++) pay[i] = $urandom;
    endtask

    task automatic check_result(input string tag, input int exp_wr, input int exp_resp, input bit exp_boot);
        repeat (15 * CPB) tick();
        chk({tag, ".nwr"}, wr_addr_q.size(), exp_wr);
        for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
            chk({tag, ".addr"}, wr_addr_q[i], i);
            chk({tag, ".data"}, wr_data_q[i], pay[i]);
        end
        chk({tag, ".nresp"}, tx_q.size(), (exp_resp < 0) ? 0 : 1);
        if (exp_resp >= 0 && tx_q.size() > 0) chk({tag, ".resp"}, tx_q[0], exp_resp);
        chk({tag, ".booted"}, booted, exp_boot);
        chk({tag, ".core_rst"}, core_rst, !exp_boot);
        chk({tag, ".tx_idle"}, tx, 1'b1);
        tx_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        int csum, n, er;

        vt[0] = '{2,  32'h13,       32'h6F, 'h82, 1'b0, 'h06, 1'b1};
        vt[1] = '{2,  32'h13,       32'h6F, 'h83, 1'b0, 'h15, 1'b0};
        vt[2] = '{0,  32'h13,       32'h6F, 'h00, 1'b0, 'h15, 1'b0};
        vt[3] = '{17, 32'h13,       32'h6F, 'h00, 1'b0, 'h15, 1'b0};
        vt[4] = '{2,  32'h13,       32'h6F, 'h82, 1'b1, 'h06, 1'b1};
        vt[5] = '{16, 32'h01020304, 32'h0,  -1,   1'b0, 'h06, 1'b1};
        vt[6] = '{1,  32'hDEADBEEF, 32'h0,  'h38, 1'b0, 'h06, 1'b1};

        do_reset();
        chk("rst.tx", tx, 1'b1);
        chk("rst.booted", booted, 1'b0);
        chk("rst.core_rst", core_rst, 1'b1);
        chk("rst.we", we, 1'b0);
        chk("rst.addr", addr, 0);
        chk("rst.wdata", wdata, 0);

        foreach (vt[v]) begin
            half = vt[v].half;
            do_reset();
            fill_pay(vt[v].w0, vt[v].w1);
            csum = (vt[v].csum < 0) ? int'(sum_pay(vt[v].n)) : vt[v].csum;
            send_frame(vt[v].n, csum, -1, 0, -1);
            if (vt[v].exp_boot) chk($sformatf("vec%0d.boot_early", v), booted, 1'b0);
            check_result($sformatf("vec%0d", v), model_writes(vt[v].n), vt[v].exp_resp, vt[v].exp_boot);
        end
        half = 1'b0;

        // NAK leaves the loader ready for a retry
        do_reset();
        fill_pay(32'h13, 32'h6F);
        send_frame(2, 'h82 + 1, -1, 0, -1);
        check_result("retry.nak", 2, 'h15, 1'b0);
        send_frame(2, 'h82, -1, 0, -1);
        check_result("retry.ack", 2, 'h06, 1'b1);

        // framing error in the second payload byte aborts silently
        do_reset();
        send_frame(2, 'h82, 4, 0, -1);
        check_result("ferr", 0, -1, 1'b0);
        send_frame(2, 'h82, -1, 0, -1);
        check_result("ferr.recover", 2, 'h06, 1'b1);

        // inter-byte timeout after the magic byte, and a stall that stays inside it
        do_reset();
        send_frame(2, 'h82, -1, 0, 0);
        repeat (65 * CPB) tick();
        send_frame(2, 'h82, -1, 1, -1);
        check_result("timeout", 0, -1, 1'b0);
        do_reset();
        send_frame(2, 'h82, -1, 0, 0);
        repeat (40 * CPB) tick();
        send_frame(2, 'h82, -1, 1, -1);
        check_result("stall_ok", 2, 'h06, 1'b1);

        // quarter-bit glitch between count and payload is not a byte
        do_reset();
        send_frame(2, 'h82, -1, 0, 2);
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (2 * CPB) tick();
        send_frame(2, 'h82, -1, 3, -1);
        check_result("glitch", 2, 'h06, 1'b1);

        // asynchronous reset in the middle of the payload
        do_reset();
        send_frame(2, 'h82, -1, 0, 6);
        repeat (2) tick();
        chk("midrst.pre_wdata", wdata, 32'h13);
        rx = 1'b0;
        repeat (CPB) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.tx", tx, 1'b1);
        chk("midrst.booted", booted, 1'b0);
        chk("midrst.core_rst", core_rst, 1'b1);
        chk("midrst.we", we, 1'b0);
        chk("midrst.addr", addr, 0);
        chk("midrst.wdata", wdata, 0);
        do_reset();
        check_result("midrst.after", 0, -1, 1'b0);

        // once booted, further frames are ignored
        do_reset();
        fill_pay(32'h13, 32'h6F);
        send_frame(2, 'h82, -1, 0, -1);
        check_result("boot", 2, 'h06, 1'b1);
        fill_pay(32'hCAFE0001, 32'h0);
        send_frame(1, int'(sum_pay(1)), -1, 0, -1);
        check_result("post_boot", 0, -1, 1'b1);

        // randomized frames against the model
        for (int r = 0; r < 8; r++) begin
            er = $urandom_range(0, 9);
            if (er == 0)      n = 0;
            else if (er == 1) n = DEPTH + $urandom_range(1, 100);
            else              n = $urandom_range(1, 4);
            half = 1'($urandom_range(0, 1));
            do_reset();
            fill_pay($urandom, $urandom);
            csum = (n >= 1 && n <= DEPTH) ? int'(sum_pay(n)) : 0;
            if ($urandom_range(0, 1) == 0) csum = csum + $urandom_range(1, 255);
            send_frame(n, csum, -1, 0, -1);
            check_result($sformatf("rand%0d", r), model_writes(n), model_resp(n, csum),
                         model_resp(n, csum) == 'h06);
        end
        half = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_bootloader.md
Name: uart_bootloader

Overview:
- Boot front end for the rv32i top level.
- Receives a program image over UART and writes it word-by-word into instruction memory.
- Holds the core in reset during loading; answers ACK/NAK on the TX line.
- Asserts o_booted and releases the core once a checksum-valid image has been loaded.

Parameters:
CLKS_PER_BIT, 868, enabled clock cycles per UART bit (min 4)
DEPTH, 4096, instruction memory depth in 32-bit words
ADDR_W, 12, memory word-address width (clog2(DEPTH))
BASE_WORD, 0, word address of the first loaded word
TIMEOUT_BITS, 64, idle bit-times allowed between bytes mid-frame before abort

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_clk_en  in  1  clock enable; all state, including the baud counters, advances only when high
i_rx  in  1  UART receive, asynchronous, idle high
o_tx  out  1  UART transmit, idle high
o_booted  out  1  image loaded and verified
o_core_rst  out  1  reset to core; high until booted
o_mem_we  out  1  memory write strobe, one enabled cycle
o_mem_addr  out  ADDR_W  memory word address
o_mem_wdata  out  32  memory write data

Behaviour:
- Reset values: o_tx=1, o_booted=0, o_core_rst=1, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0. FSM returns to IDLE. Reset mid-transfer aborts with no response sent.
- i_clk_en: while low, every register holds. Baud counters count enabled cycles only.
- RX path: i_rx passes through a 2-flop synchroniser.
  - A falling edge starts reception.
  - The start bit is re-sampled at CLKS_PER_BIT/2. If it is high, this is a false start; return to line idle.
  - Data bits are sampled at bit centres, LSB first.
  - The stop bit must be 1. A 0 is a framing error: discard the byte and abort the frame silently to IDLE.
- Frame format, all fields little-endian:
  - magic byte 0xB0
  - count: 2 bytes, N words
  - payload: N×4 bytes
  - checksum: 1 byte, sum mod 256 of all payload bytes
- FSM states: IDLE, CNT_LO, CNT_HI, PAYLOAD, CSUM, RESP, BOOTED.
  - IDLE: 0xB0 → CNT_LO. Any other byte is ignored.
  - CNT_HI complete:
    - N==0 or N>DEPTH-BASE_WORD → RESP with NAK.
    - Otherwise clear the word index and checksum → PAYLOAD.
  - PAYLOAD:
    - Bytes assemble into a 32-bit word, first byte into bits 7:0.
    - Every payload byte is added to an 8-bit wrapping checksum.
    - On the 4th byte, o_mem_we pulses for exactly one enabled cycle with o_mem_addr=BASE_WORD+index and o_mem_wdata=word. Write latency is 1 enabled cycle after the stop-bit sample.
    - Index increments after each word write. After word N-1 → CSUM.
  - CSUM: received byte == checksum → RESP with ACK 0x06; else RESP with NAK 0x15.
  - RESP: transmit 8N1, CLKS_PER_BIT per bit.
    - After ACK: → BOOTED; o_booted=1 and o_core_rst=0 on the same enabled cycle, after the stop bit completes.
    - After NAK: → IDLE. Memory contents are left partially written; the host retries.
- Inter-byte timeout: in CNT_LO, CNT_HI, PAYLOAD or CSUM, if TIMEOUT_BITS×CLKS_PER_BIT enabled cycles pass without a start bit → IDLE, no response.
- BOOTED is terminal until i_rst:
  - RX is ignored and no writes occur.
  - o_tx stays 1.
- Bytes arriving during RESP are dropped. The TX byte is never truncated.
- o_mem_addr and o_mem_wdata hold their last values between writes.

Test Plan:
- CLKS_PER_BIT=4, BASE_WORD=0. Send B0 02 00 | 13 00 00 00 | 6F 00 00 00 | 82 → two writes (addr0=0x00000013, addr1=0x0000006F), TX 0x06, o_booted=1, o_core_rst=0.
- Same frame with checksum 0x83 → two writes occur, TX 0x15, o_booted=0, FSM back in IDLE. Resend with 0x82 → ACK and boot.
- Count 0x0000, then count DEPTH+1 → NAK each, no o_mem_we pulse.
- Stop bit forced to 0 in the 2nd payload byte → no response, no write, IDLE; a following valid frame boots.
- Stall 65 bit-times after CNT_LO → silent abort. A 0.25-bit low glitch on i_rx → no byte decoded.
- i_clk_en at 50% duty → identical results at half rate. Assert i_rst mid-PAYLOAD → all outputs return to reset values immediately. After boot, a further frame → no writes, o_booted stays 1.
